// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencer.
// Optional memory-wait timeout is enabled by defining MC_TIMEOUT_EN.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC_R = 4'd2,
        ST_EXEC_I = 4'd3,
        ST_ADDR   = 4'd4,
        ST_MEM_RD = 4'd5,
        ST_MEM_WR = 4'd6,
        ST_WB     = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_TRAP   = 4'd10
    } state_e;

    typedef enum logic [3:0] {
        CL_R, CL_JR, CL_JALR, CL_IMM, CL_LOAD,
        CL_STORE, CL_BR, CL_J, CL_JAL, CL_ILLEGAL
    } class_e;

    typedef enum logic [2:0] {
        BC_BEQ, BC_BNE, BC_BGEZ, BC_BLTZ, BC_BGTZ, BC_BLEZ
    } br_cond_e;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [2:0] OP_IMM_HI  = 3'b001;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] RT_BLTZ    = 5'd0;
    localparam logic [4:0] RT_BGEZ    = 5'd1;

    localparam logic [1:0] PC_PLUS4   = 2'd0;
    localparam logic [1:0] PC_BRANCH  = 2'd1;
    localparam logic [1:0] PC_JUMP    = 2'd2;
    localparam logic [1:0] PC_RS      = 2'd3;

    localparam logic [1:0] WB_ALU     = 2'd0;
    localparam logic [1:0] WB_MDR     = 2'd1;
    localparam logic [1:0] WB_LINK    = 2'd2;

    localparam logic [1:0] DST_RT     = 2'd0;
    localparam logic [1:0] DST_RD     = 2'd1;
    localparam logic [1:0] DST_R31    = 2'd2;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

    localparam logic [7:0] TIMEOUT = 8'd255;

    function automatic logic br_taken(input br_cond_e cond, input logic zero,
                                      input logic neg);
        case (cond)
            BC_BEQ:  return zero;
            BC_BNE:  return !zero;
            BC_BGEZ: return !neg;
            BC_BLTZ: return neg;
            BC_BGTZ: return !neg && !zero;
            BC_BLEZ: return neg || zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_sequencer_class_decode.sv
// Combinational instruction classifier: op/func/rt to class and branch condition.
module mc_class_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic [4:0] rt,
    output class_e     cls,
    output br_cond_e   cond
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        cls  = CL_ILLEGAL;
        cond = BC_BEQ;
        case (op)
            OP_SPECIAL: begin
                if (func == FN_JR)        cls = CL_JR;
                else if (func == FN_JALR) cls = CL_JALR;
                else                      cls = CL_R;
            end
            OP_LW, OP_LB, OP_LBU: cls = CL_LOAD;
            OP_SW, OP_SB:         cls = CL_STORE;
            OP_BEQ: begin cls = CL_BR; cond = BC_BEQ; end
            OP_BNE: begin cls = CL_BR; cond = BC_BNE; end
            OP_REGIMM: begin
                if (rt == RT_BLTZ) begin
                    cls  = CL_BR;
                    cond = BC_BLTZ;
                end else if (rt == RT_BGEZ) begin
                    cls  = CL_BR;
                    cond = BC_BGEZ;
                end
            end
            OP_BLEZ: if (rt == 5'd0) begin cls = CL_BR; cond = BC_BLEZ; end
            OP_BGTZ: if (rt == 5'd0) begin cls = CL_BR; cond = BC_BGTZ; end
            OP_J:    cls = CL_J;
            OP_JAL:  cls = CL_JAL;
            default: if (op[5:3] == OP_IMM_HI) cls = CL_IMM;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS sequencer: owns write strobes and the shared memory port.
// Define MC_TIMEOUT_EN to trap on memory waits longer than TIMEOUT cycles.
module mc_sequencer
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic [4:0] rt,
    input  logic       zero,
    input  logic       alu_neg,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       reg_wr,
    output logic [1:0] wb_sel,
    output logic [1:0] dst_sel,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state
);

    state_e   state_q, state_d;
    class_e   class_q, class_d, dec_class;
    br_cond_e cond_q, cond_d, dec_cond;
    logic [1:0] cause_q, cause_d;
    logic       timeout_hit;

    mc_class_decode u_class_decode (
        .op   (op),
        .func (func),
        .rt   (rt),
        .cls  (dec_class),
        .cond (dec_cond)
    );

`ifdef MC_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Any state change is an entry into FETCH/MEM_RD/MEM_WR or a state that never waits.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (mem_req && !mem_ready)
            wait_cnt_d = wait_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end

    // This waiting cycle brings the count to TIMEOUT; an ack in it still wins.
    assign timeout_hit = (wait_cnt_q == TIMEOUT - 8'd1);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_FETCH;
            class_q <= CL_ILLEGAL;
            cond_q  <= BC_BEQ;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cond_q  <= cond_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        cond_d     = cond_q;
        cause_d    = cause_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = PC_PLUS4;
        reg_wr     = 1'b0;
        wb_sel     = WB_ALU;
        dst_sel    = DST_RT;
        retire     = 1'b0;
        trap       = 1'b0;
        trap_cause = TRAP_NONE;

        // Reset silences every output combinationally, dropping any request at once.
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_wr   = 1'b1;
                        pc_wr   = 1'b1;
                        state_d = ST_DECODE;
                    end else if (timeout_hit) begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    class_d = dec_class;
                    cond_d  = dec_cond;
                    case (dec_class)
                        CL_R:                              state_d = ST_EXEC_R;
                        CL_IMM:                            state_d = ST_EXEC_I;
                        CL_LOAD, CL_STORE:                 state_d = ST_ADDR;
                        CL_BR:                             state_d = ST_BRANCH;
                        CL_JR, CL_JALR, CL_J, CL_JAL:      state_d = ST_JUMP;
                        default: begin
                            state_d = ST_TRAP;
                            cause_d = TRAP_ILLEGAL;
                        end
                    endcase
                end
                ST_EXEC_R, ST_EXEC_I: state_d = ST_WB;
                ST_ADDR: state_d = (class_q == CL_LOAD) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_ready) begin
                        state_d = ST_WB;
                    end else if (timeout_hit) begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_TIMEOUT;
                    end
                end
                ST_MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else if (timeout_hit) begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_TIMEOUT;
                    end
                end
                ST_WB: begin
                    reg_wr  = 1'b1;
                    retire  = 1'b1;
                    wb_sel  = (class_q == CL_LOAD) ? WB_MDR : WB_ALU;
                    dst_sel = (class_q == CL_R) ? DST_RD : DST_RT;
                    state_d = ST_FETCH;
                end
                ST_BRANCH: begin
                    pc_src  = PC_BRANCH;
                    pc_wr   = br_taken(cond_q, zero, alu_neg);
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_JUMP: begin
                    pc_wr   = 1'b1;
                    retire  = 1'b1;
                    pc_src  = (class_q == CL_JR || class_q == CL_JALR) ? PC_RS : PC_JUMP;
                    if (class_q == CL_JAL || class_q == CL_JALR) begin
                        reg_wr  = 1'b1;
                        wb_sel  = WB_LINK;
                        dst_sel = (class_q == CL_JAL) ? DST_R31 : DST_RD;
                    end
                    state_d = ST_FETCH;
                end
                ST_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    assign state = rst ? 4'd0 : state_q;

endmodule
